// File: rtl/demux32_8_pkg.sv
// Shared definitions for the byte-lane link packer/unpacker pair.
package demux32_8_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned CNT_W          = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte at stream position idx (0 = first on the wire) for the chosen order.
    function automatic logic [BYTE_W-1:0] byte_sel(
        input logic [WORD_W-1:0] word,
        input logic [CNT_W-1:0]  idx,
        input logic              msb_first
    );
        logic [CNT_W-1:0] pos;
        pos = msb_first ? (CNT_W'(BYTES_PER_WORD - 1) - idx) : idx;
        return word[32'(pos) * BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/demux32_8_word_hold_reg.sv
// One-entry word holding register with load/take and an occupancy flag.
module demux32_8_word_hold_reg
    import demux32_8_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         clk_4f,
    input  logic         reset_L,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         hold_valid
);

    // Load wins over take; the owner never asserts both in one cycle.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            q          <= '0;
            hold_valid <= 1'b0;
        end else if (load) begin
            q          <= d;
            hold_valid <= 1'b1;
        end else if (take) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux32_8.sv
// Word-to-byte unpacker: emits four bytes per accepted word on clk_4f with a
// one-word holding register so back-to-back words stream without gaps.
module demux32_8 #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out
);
    import demux32_8_pkg::state_t;
    import demux32_8_pkg::IDLE;
    import demux32_8_pkg::SEND;
    import demux32_8_pkg::byte_sel;

    localparam logic [1:0] LAST_IDX = 2'd3;

    if (WORD_W != demux32_8_pkg::WORD_W || BYTE_W != demux32_8_pkg::BYTE_W) begin : g_width_check
        $error("demux32_8 supports only 32-bit words of 8-bit bytes");
    end

    state_t            state;
    logic [1:0]        cnt;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] hold_q;
    logic              hold_valid;
    logic              accept;
    logic              last_byte;
    logic              hold_load;
    logic              hold_take;
    logic              msb_first;

    assign msb_first = (MSB_FIRST != 0);
    assign ready_out = reset_L && !hold_valid;
    assign accept    = valid_in && ready_out;
    assign last_byte = (state == SEND) && (cnt == LAST_IDX);
    // A word arriving mid-word parks in the hold register; at the last byte it bypasses.
    assign hold_load = accept && (state == SEND) && !last_byte;
    assign hold_take = last_byte && hold_valid;

    demux32_8_word_hold_reg #(
        .W(WORD_W)
    ) u_hold (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .load      (hold_load),
        .take      (hold_take),
        .d         (data_in),
        .q         (hold_q),
        .hold_valid(hold_valid)
    );

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            cur_word  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_word  <= data_in;
                        data_out  <= byte_sel(data_in, 2'd0, msb_first);
                        valid_out <= 1'b1;
                        cnt       <= 2'd0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (!last_byte) begin
                        cnt      <= cnt + 2'd1;
                        data_out <= byte_sel(cur_word, cnt + 2'd1, msb_first);
                    end else if (hold_valid) begin
                        cur_word <= hold_q;
                        data_out <= byte_sel(hold_q, 2'd0, msb_first);
                        cnt      <= 2'd0;
                    end else if (accept) begin
                        cur_word <= data_in;
                        data_out <= byte_sel(data_in, 2'd0, msb_first);
                        cnt      <= 2'd0;
                    end else begin
                        data_out  <= '0;
                        valid_out <= 1'b0;
                        cnt       <= 2'd0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/demux32_8.md
Name: demux32_8

Overview:
Unpacks 32-bit words into a serial 8-bit byte stream for the transmit side of the byte-lane link. It is the inverse of the 8-to-32 packer and emits four bytes per word on clk_4f. By default byte order is MSB first: bits [31:24] go out first, matching how the packer fills its word. A one-word holding register lets an upstream source at clk_f rate, one word per 4 cycles, produce a gapless byte stream.

Parameters:
WORD_W, 32, input word width; must equal BYTE_W*4
BYTE_W, 8, output byte width
MSB_FIRST, 1, 1: emit [31:24] first; 0: emit [7:0] first

Ports:
clk_4f  input  1  single clock, byte rate; all logic on rising edge
reset_L  input  1  synchronous, active-low reset
data_in  input  WORD_W  word to unpack
valid_in  input  1  data_in valid; word accepted on an edge where valid_in && ready_out
ready_out  output  1  block can accept a word; = reset_L && !hold_valid
data_out  output  BYTE_W  current byte, registered
valid_out  output  1  data_out valid, registered

Behaviour:
- Reset, sampled at the clk_4f edge while reset_L=0:
  - data_out=0, valid_out=0, hold_valid=0, byte count cnt=0, state=IDLE.
  - ready_out=0 while reset_L is low.
  - Reset mid-word discards the current word and the held word. No partial bytes appear after reset.
- State machine:
  - IDLE: no byte on output.
  - SEND: a byte is on output; cnt (2 bits) holds the index of the displayed byte, 0..3.
- IDLE with word accepted at edge k: data_out=byte0 and valid_out=1 after edge k (1-cycle latency). Remaining bytes go to the shift register, cnt=0, state=SEND. Bytes 1..3 follow at edges k+1..k+3.
- SEND with cnt<3: each edge emits the next byte and increments cnt.
- SEND with cnt==3 (last byte displayed), next edge, in priority order:
  - a) hold_valid=1: load byte0 of the held word, clear hold_valid, cnt=0, stay in SEND.
  - b) else if a word is accepted this edge: bypass straight to output as byte0, cnt=0, stay in SEND.
  - c) else: valid_out=0, data_out=0, state=IDLE.
- A word accepted in SEND that is not case (b) is written to the hold register, setting hold_valid.
- While hold_valid=1, ready_out=0. A word offered at the edge where hold drains is not accepted that cycle.
- Byte order:
  - MSB_FIRST=1: bytes in order [31:24], [23:16], [15:8], [7:0].
  - MSB_FIRST=0: bytes in order [7:0] … [31:24].
- Throughput:
  - Sustained rate is 1 word per 4 cycles with no output gaps.
  - valid_in held high back-to-back: second word held, ready_out low until drained, no loss or reordering.
- valid_out is high only on cycles where data_out is a real byte. There is no downstream backpressure.
- When IDLE, data_out=0. valid_out never toggles mid-word.

Decomposition:
- Shared package:
  - BYTE_W, BYTES_PER_WORD=4, WORD_W.
  - State encoding: IDLE=1'b0, SEND=1'b1.
  - Byte-index select function used by both packer and unpacker.
- Sub-module word_hold_reg: one-entry register with load and take, plus a hold_valid flag, reset on reset_L. It is reusable by the packer's output side.

Test Plan:
- Reset: reset_L=0 for 2 edges, valid_in=1, data_in=0xFFFFFFFF -> data_out=0x00, valid_out=0, ready_out=0 throughout; nothing emitted after release.
- Single word 0xDEADBEEF accepted at edge k -> data_out DE,AD,BE,EF after edges k..k+3; valid_out=1 exactly 4 cycles; then valid_out=0, data_out=0x00.
- Words 0x01020304 and 0x05060708 offered one every 4 cycles -> 8 contiguous valid bytes 01..08, second word via bypass, hold never used.
- valid_in held high with A=0x11223344, B=0x55667788, C=0x99AABBCC:
  - A goes direct, B goes to hold, ready_out=0 until B loads.
  - 12 contiguous bytes 11..CC in order, no duplicate or lost word.
- Reset asserted after 2 bytes of 0xCAFEF00D with B held -> valid_out=0 next edge, hold cleared. New word 0x0A0B0C0D after release emits 0A,0B,0C,0D only.
- MSB_FIRST=0, word 0xDEADBEEF -> EF,BE,AD,DE.
